// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with double-buffered glyph codes,
// frame-aligned commit, anti-ghost blanking, per-digit blink and pin polarity.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK        = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [7:0]                wr_code,
    input  logic                      wr_dp,
    input  logic                      commit,
    input  logic [DIGITS-1:0]         blink_mask,
    output logic                      busy,
    output logic                      commit_done,
    output logic                      frame_tick,
    output logic [7:0]                seg,
    output logic [DIGITS-1:0]         dig_sel
);

    localparam int AW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [7:0] CODE_BLANK = 8'd34;
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [PW-1:0]     pre;
    logic [AW-1:0]     idx;
    logic [7:0]        sh_code [DIGITS];
    logic [7:0]        ac_code [DIGITS];
    logic [DIGITS-1:0] sh_dp;
    logic [DIGITS-1:0] ac_dp;
    logic [FW-1:0]     fcnt;
    logic              phase;
    logic              busy_q;
    logic              done_q;
    logic              tick_q;
    logic [7:0]        seg_q;
    logic [DIGITS-1:0] dig_q;

    logic              pre_end;
    logic              idx_end;
    logic              wrap;
    logic              copy;
    logic [7:0]        seg_n;
    logic [DIGITS-1:0] dig_n;

    function automatic logic [7:0] glyph(input logic [7:0] c);
        case (c)
            8'd0:  glyph = 8'hFC;
            8'd1:  glyph = 8'h60;
            8'd2:  glyph = 8'hDA;
            8'd3:  glyph = 8'hF2;
            8'd4:  glyph = 8'h66;
            8'd5:  glyph = 8'hB6;
            8'd6:  glyph = 8'hBE;
            8'd7:  glyph = 8'hE4;
            8'd8:  glyph = 8'hFE;
            8'd9:  glyph = 8'hF6;
            8'd10: glyph = 8'hEE;
            8'd11: glyph = 8'h3E;
            8'd12: glyph = 8'h34;
            8'd13: glyph = 8'h7A;
            8'd14: glyph = 8'h9E;
            8'd15: glyph = 8'h8E;
            8'd16: glyph = 8'hBC;
            8'd17: glyph = 8'h6E;
            8'd18: glyph = 8'h0C;
            8'd19: glyph = 8'h70;
            8'd20: glyph = 8'h0E;
            8'd21: glyph = 8'h1C;
            8'd22: glyph = 8'h2A;
            8'd23: glyph = 8'h3A;
            8'd24: glyph = 8'hCE;
            8'd25: glyph = 8'hE6;
            8'd26: glyph = 8'h0A;
            8'd27: glyph = 8'hB6;
            8'd28: glyph = 8'h1E;
            8'd29: glyph = 8'h38;
            8'd30: glyph = 8'h38;
            8'd31: glyph = 8'h66;
            8'd32: glyph = 8'hDA;
            8'd33: glyph = 8'h6C;
            8'd34: glyph = 8'h00;
            8'd35: glyph = 8'hFF;
            8'd36: glyph = 8'h02;
            default: glyph = 8'hFF;
        endcase
    endfunction

    assign pre_end = (pre == PW'(SCAN_DIV - 1));
    assign idx_end = (idx == AW'(DIGITS - 1));
    assign wrap    = pre_end && idx_end;
    assign copy    = wrap && busy_q;

    always_comb begin
        seg_n = glyph(ac_code[idx]) | {7'b0, ac_dp[idx]};
        if (phase && blink_mask[idx]) seg_n = 8'h00;
        dig_n = DIGITS'(1) << idx;
        // Anti-ghost: all digits off while the segment bus settles
        if (32'(pre) < BLANK) dig_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre    <= '0;
            idx    <= '0;
            fcnt   <= '0;
            phase  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tick_q <= 1'b0;
            sh_dp  <= '0;
            ac_dp  <= '0;
            seg_q  <= INV ? 8'hFF : 8'h00;
            dig_q  <= {DIGITS{INV}};
            for (int i = 0; i < DIGITS; i++) begin
                sh_code[i] <= CODE_BLANK;
                ac_code[i] <= CODE_BLANK;
            end
        end else begin
            pre    <= pre_end ? '0 : pre + 1'b1;
            tick_q <= wrap;
            done_q <= copy;
            if (pre_end) idx <= idx_end ? '0 : idx + 1'b1;
            if (wrap) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            // A commit landing on the copy cycle re-arms for the next frame
            if (copy) begin
                busy_q <= commit;
                ac_dp  <= sh_dp;
                for (int i = 0; i < DIGITS; i++)
                    ac_code[i] <= sh_code[i];
            end else if (commit) begin
                busy_q <= 1'b1;
            end
            if (wr_en && (32'(wr_addr) < DIGITS)) begin
                sh_code[wr_addr] <= wr_code;
                sh_dp[wr_addr]   <= wr_dp;
            end
            seg_q <= INV ? ~seg_n : seg_n;
            dig_q <= INV ? ~dig_n : dig_n;
        end
    end

    assign busy        = busy_q;
    assign commit_done = done_q;
    assign frame_tick  = tick_q;
    assign seg         = seg_q;
    assign dig_sel     = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench for seg7_scan_driver: an active-high and an active-low
// instance share stimulus; a cycle model queues expected pins per clock.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_code = 8'd0;
    logic       wr_dp = 1'b0;
    logic       commit = 1'b0;
    logic [3:0] blink_mask = 4'd0;

    logic       busy_a, cd_a, ft_a, busy_b, cd_b, ft_b;
    logic [7:0] seg_a, seg_b;
    logic [3:0] dig_a, dig_b;
    logic [29:0] obs;

    logic [29:0] sb [$];
    int total = 0;
    int bad = 0;

    logic [7:0] rom [37] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE4,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h34, 8'h7A, 8'h9E, 8'h8E,
        8'hBC, 8'h6E, 8'h0C, 8'h70, 8'h0E, 8'h1C, 8'h2A, 8'h3A,
        8'hCE, 8'hE6, 8'h0A, 8'hB6, 8'h1E, 8'h38, 8'h38, 8'h66,
        8'hDA, 8'h6C, 8'h00, 8'hFF, 8'h02};

    always #5 clk = ~clk;

    assign obs = {seg_a, dig_a, busy_a, cd_a, ft_a,
                  seg_b, dig_b, busy_b, cd_b, ft_b};

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLANK(1),
        .BLINK_FRAMES(2), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_code(wr_code), .wr_dp(wr_dp), .commit(commit),
        .blink_mask(blink_mask), .busy(busy_a), .commit_done(cd_a),
        .frame_tick(ft_a), .seg(seg_a), .dig_sel(dig_a)
    );

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLANK(1),
        .BLINK_FRAMES(2), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_code(wr_code), .wr_dp(wr_dp), .commit(commit),
        .blink_mask(blink_mask), .busy(busy_b), .commit_done(cd_b),
        .frame_tick(ft_b), .seg(seg_b), .dig_sel(dig_b)
    );

    // Reference model: pushes the pin values expected after each edge
    initial begin : model
        int m_pre, m_idx, m_fc;
        int m_code [4];
        int a_code [4];
        bit m_dp [4];
        bit a_dp [4];
        bit m_ph, m_busy, w, cd, nb;
        logic [7:0] s;
        logic [3:0] d;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pre = 0; m_idx = 0; m_fc = 0; m_ph = 0; m_busy = 0;
                for (int i = 0; i < 4; i++) begin
                    m_code[i] = 34; a_code[i] = 34;
                    m_dp[i] = 0; a_dp[i] = 0;
                end
                sb.push_back({8'h00, 4'h0, 3'b000, 8'hFF, 4'hF, 3'b000});
            end else begin
                s = (a_code[m_idx] <= 36) ? rom[a_code[m_idx]] : 8'hFF;
                s[0] = s[0] | a_dp[m_idx];
                if (m_ph && blink_mask[m_idx]) s = 8'h00;
                d = (m_pre < 1) ? 4'h0 : 4'(4'b0001 << m_idx);
                w = (m_pre == 3) && (m_idx == 3);
                cd = w && m_busy;
                nb = cd ? commit : (m_busy || commit);
                if (cd) begin
                    for (int i = 0; i < 4; i++) begin
                        a_code[i] = m_code[i];
                        a_dp[i] = m_dp[i];
                    end
                end
                if (wr_en) begin
                    m_code[wr_addr] = int'(wr_code);
                    m_dp[wr_addr] = wr_dp;
                end
                if (w) begin
                    if (m_fc == 1) begin m_fc = 0; m_ph = !m_ph; end
                    else m_fc++;
                end
                m_busy = nb;
                m_pre = (m_pre + 1) % 4;
                if (m_pre == 0) m_idx = (m_idx + 1) % 4;
                sb.push_back({s, d, nb, cd, w, ~s, ~d, nb, cd, w});
            end
        end
    end

    task automatic test_reset();
        logic [29:0] e;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_sb got=%h exp=%h", obs, e);
            end
            total++;
            if ({seg_a, dig_a, busy_a, seg_b, dig_b, busy_b} !==
                {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF, 1'b0}) begin
                bad++;
                $display("FAIL reset_pins got=%h/%h/%h %h/%h/%h exp=00/0/0 FF/F/0",
                         seg_a, dig_a, busy_a, seg_b, dig_b, busy_b);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [29:0] e;
        logic [3:0] xd;
        int ticks = 0;
        int first = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL scan_sb c=%0d got=%h exp=%h", c, obs, e);
            end
            xd = ((c - 1) % 4 == 0) ? 4'h0 : 4'(4'b0001 << (((c - 1) / 4) % 4));
            total++;
            if (dig_a !== xd || seg_a !== 8'h00) begin
                bad++;
                $display("FAIL scan_pins c=%0d got=%h/%h exp=%h/00",
                         c, dig_a, seg_a, xd);
            end
            if (ft_a) begin
                ticks++;
                if (first < 0) first = c;
            end
        end
        total++;
        if (ticks != 2 || first != 16) begin
            bad++;
            $display("FAIL frame_tick got=%0d@%0d exp=2@16", ticks, first);
        end
    endtask

    task automatic test_commit();
        logic [29:0] e;
        logic [7:0] xs [4];
        int dn = 0;
        bit seen = 0;
        xs = '{8'h60, 8'hDA, 8'hF2, 8'h66};
        for (int c = 0; c < 46; c++) begin
            wr_en = (c < 4);
            wr_addr = 2'(c);
            wr_code = 8'(c + 1);
            wr_dp = 1'b0;
            commit = (c == 4 || c == 5);
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL commit_sb c=%0d got=%h exp=%h", c, obs, e);
            end
            if (c >= 4) begin
                if (!seen && !cd_a) begin
                    total++;
                    if (busy_a !== 1'b1) begin
                        bad++;
                        $display("FAIL commit_busy c=%0d got=%b exp=1", c, busy_a);
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (seen && dig_a[i]) begin
                        total++;
                        if (seg_a !== xs[i]) begin
                            bad++;
                            $display("FAIL commit_seg d=%0d got=%h exp=%h",
                                     i, seg_a, xs[i]);
                        end
                    end
                end
                if (cd_a) begin dn++; seen = 1; end
            end
        end
        wr_en = 1'b0;
        commit = 1'b0;
        total++;
        if (dn != 1) begin
            bad++;
            $display("FAIL commit_done_count got=%0d exp=1", dn);
        end
    endtask

    task automatic test_shadow();
        logic [29:0] e;
        int dn = 0;
        bit seen = 0;
        for (int c = 0; c < 50; c++) begin
            wr_en = (c == 0);
            wr_addr = 2'd0;
            wr_code = 8'd8;
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL shadow_sb c=%0d got=%h exp=%h", c, obs, e);
            end
            if (dig_a[0]) begin
                total++;
                if (seg_a !== 8'h60) begin
                    bad++;
                    $display("FAIL shadow_hidden got=%h exp=60", seg_a);
                end
            end
        end
        wr_en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            commit = (c == 0);
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL shadow_sb2 c=%0d got=%h exp=%h", c, obs, e);
            end
            if (seen && dig_a[0]) begin
                total++;
                if (seg_a !== 8'hFE) begin
                    bad++;
                    $display("FAIL shadow_commit got=%h exp=FE", seg_a);
                end
            end
            if (cd_a) begin dn++; seen = 1; end
        end
        commit = 1'b0;
        total++;
        if (dn != 1) begin
            bad++;
            $display("FAIL shadow_done_count got=%0d exp=1", dn);
        end
    endtask

    task automatic test_blink();
        logic [29:0] e;
        logic [7:0] xs [4];
        bit found = 0;
        int n_on = 0;
        int n_off = 0;
        xs = '{8'hFE, 8'hDA, 8'hF2, 8'h66};
        blink_mask = 4'b0001;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL blink_sb_sync got=%h exp=%h", obs, e);
            end
            if (ft_a) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL blink_sync got=no_tick exp=tick");
        end
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL blink_sb c=%0d got=%h exp=%h", c, obs, e);
            end
            if (dig_a[0]) begin
                if (seg_a === 8'h00) n_off++;
                if (seg_a === 8'hFE) n_on++;
            end
            for (int i = 1; i < 4; i++) begin
                if (dig_a[i]) begin
                    total++;
                    if (seg_a !== xs[i]) begin
                        bad++;
                        $display("FAIL blink_other d=%0d got=%h exp=%h",
                                 i, seg_a, xs[i]);
                    end
                end
            end
        end
        blink_mask = 4'b0000;
        total++;
        if (n_on != 6 || n_off != 6) begin
            bad++;
            $display("FAIL blink_split got=on%0d/off%0d exp=on6/off6",
                     n_on, n_off);
        end
    endtask

    task automatic test_dp_overflow();
        logic [29:0] e;
        logic [7:0] xs [4];
        int dn = 0;
        bit seen = 0;
        xs = '{8'hFE, 8'hFD, 8'hFF, 8'h66};
        for (int c = 0; c < 44; c++) begin
            wr_en = (c < 2);
            wr_addr = (c == 0) ? 2'd2 : 2'd1;
            wr_code = (c == 0) ? 8'd40 : 8'd0;
            wr_dp = 1'b1;
            commit = (c == 2);
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL dp_sb c=%0d got=%h exp=%h", c, obs, e);
            end
            for (int i = 0; i < 4; i++) begin
                if (seen && dig_a[i]) begin
                    total++;
                    if (seg_a !== xs[i]) begin
                        bad++;
                        $display("FAIL dp_seg d=%0d got=%h exp=%h",
                                 i, seg_a, xs[i]);
                    end
                end
            end
            if (cd_a) begin dn++; seen = 1; end
        end
        wr_en = 1'b0;
        wr_dp = 1'b0;
        commit = 1'b0;
        total++;
        if (dn != 1) begin
            bad++;
            $display("FAIL dp_done_count got=%0d exp=1", dn);
        end
    endtask

    task automatic test_reset_mid_commit();
        logic [29:0] e;
        bit found = 0;
        int dn = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rmc_sb_sync got=%h exp=%h", obs, e);
            end
            if (ft_a) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rmc_sync got=no_tick exp=tick");
        end
        for (int c = 0; c < 44; c++) begin
            wr_en = (c == 0);
            wr_addr = 2'd0;
            wr_code = 8'd5;
            commit = (c == 0);
            rst = (c == 3);
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : {30{1'bx}};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rmc_sb c=%0d got=%h exp=%h", c, obs, e);
            end
            if (c == 2) begin
                total++;
                if (busy_a !== 1'b1) begin
                    bad++;
                    $display("FAIL rmc_pending got=%b exp=1", busy_a);
                end
            end
            if (c >= 3) begin
                total++;
                if ({busy_a, seg_a, seg_b} !== {1'b0, 8'h00, 8'hFF}) begin
                    bad++;
                    $display("FAIL rmc_blank c=%0d got=%b/%h/%h exp=0/00/FF",
                             c, busy_a, seg_a, seg_b);
                end
            end
            if (c == 3) begin
                total++;
                if ({dig_a, dig_b} !== {4'h0, 4'hF}) begin
                    bad++;
                    $display("FAIL rmc_dig got=%h/%h exp=0/F", dig_a, dig_b);
                end
            end
            if (cd_a) dn++;
        end
        wr_en = 1'b0;
        commit = 1'b0;
        rst = 1'b0;
        total++;
        if (dn != 0) begin
            bad++;
            $display("FAIL rmc_done_count got=%0d exp=0", dn);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_commit();
        test_shadow();
        test_blink();
        test_dp_overflow();
        test_reset_mid_commit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
